// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate-extension unit (decode -> ALU operand mux).
//   Widens an IN_W-bit immediate to OUT_W bits in zero / sign / upper / branch mode.
//   Result is registered (latency 1) behind an output register plus a one-entry
//   skid register, giving full throughput under back-pressure.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_imm[IN_W], in_mode[2] (00 zero, 01 sign,
//                        10 upper, 11 branch = sign-extended << SHIFT)
//   out_valid/out_ready  output handshake; out_data[OUT_W], out_neg = out_data MSB
//   stat_clr, stat_neg_cnt[16]  present only with IMMEXT_STATS_EN defined:
//                        saturating count of output transfers with out_neg=1
// Optional feature macro: IMMEXT_STATS_EN
module imm_ext_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef IMMEXT_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      stat_neg_cnt,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    localparam int unsigned UP_SH = OUT_W - IN_W;

    logic [OUT_W-1:0] zext_c;
    logic [OUT_W-1:0] sext_c;
    logic [OUT_W-1:0] ext_c;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_neg_q,   out_neg_d;
    logic             sr_valid_q,  sr_valid_d;
    logic [OUT_W-1:0] sr_data_q,   sr_data_d;
    logic             in_ready_q,  in_ready_d;

    logic in_xfer_c;
    logic or_free_c;

    // Extension of the incoming immediate
    always_comb begin
        zext_c = OUT_W'(in_imm);
        sext_c = OUT_W'($signed(in_imm));
        ext_c  = zext_c;
        case (in_mode)
            2'b00:   ext_c = zext_c;
            2'b01:   ext_c = sext_c;
            2'b10:   ext_c = zext_c << UP_SH;
            default: ext_c = sext_c << SHIFT;
        endcase
    end

    assign in_xfer_c = in_valid & in_ready_q;
    // OR can take a new value if empty or handing its beat off this cycle
    assign or_free_c = ~out_valid_q | out_ready;

    // Output / skid register next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sr_valid_d  = sr_valid_q;
        sr_data_d   = sr_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Skid contents advance first so ordering is preserved
        if (sr_valid_q && or_free_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sr_data_q;
            sr_valid_d  = 1'b0;
        end

        if (in_xfer_c) begin
            if (!sr_valid_q && or_free_c) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_c;
            end else begin
                sr_valid_d = 1'b1;
                sr_data_d  = ext_c;
            end
        end

        out_neg_d  = out_data_d[OUT_W-1];
        in_ready_d = ~sr_valid_d;
    end

    // Pipeline state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_neg_q   <= 1'b0;
            sr_valid_q  <= 1'b0;
            sr_data_q   <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_neg_q   <= out_neg_d;
            sr_valid_q  <= sr_valid_d;
            sr_data_q   <= sr_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_neg   = out_neg_q;

`ifdef IMMEXT_STATS_EN
    logic [15:0] stat_cnt_q, stat_cnt_d;

    // Saturating negative-result counter; clear wins over increment
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (stat_clr) begin
            stat_cnt_d = '0;
        end else if (out_valid_q && out_ready && out_neg_q && (stat_cnt_q != 16'hFFFF)) begin
            stat_cnt_d = stat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_neg_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed testbench for imm_ext_pipe (IN_W=16, OUT_W=32, SHIFT=2).
module tb_imm_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;
`ifdef IMMEXT_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_neg_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef IMMEXT_STATS_EN
        .stat_clr    (stat_clr),
        .stat_neg_cnt(stat_neg_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b01; out_ready = 1'b1;
`ifdef IMMEXT_STATS_EN
        stat_clr = 1'b0;
`endif
        tick(); tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 00000000", out_data); end
        n_vec++; if (out_neg !== 1'b0) begin n_err++; $display("FAIL reset_neg got %b want 0", out_neg); end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_modes();
        logic [1:0]  md [6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11};
        logic [15:0] im [6] = '{16'h0005, 16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0010};
        logic [31:0] ex [6] = '{32'h00000005, 32'hFFFF8000, 32'h00008000,
                                32'h12340000, 32'hFFFFFFFC, 32'h00000040};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mode%0d_pre_valid got %b want 0", i, out_valid); end
            in_valid = 1'b1; in_mode = md[i]; in_imm = im[i];
            tick();
            in_valid = 1'b0;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mode%0d_valid got %b want 1", i, out_valid); end
            n_vec++; if (out_data !== ex[i]) begin n_err++; $display("FAIL mode%0d_data got %h want %h", i, out_data, ex[i]); end
            n_vec++; if (out_neg !== ex[i][31]) begin n_err++; $display("FAIL mode%0d_neg got %b want %b", i, out_neg, ex[i][31]); end
            tick();
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_mode = 2'b00;
        in_valid = 1'b1; in_imm = 16'h1000;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream%0d_valid got %b want 1", i, out_valid); end
            n_vec++; if (out_data !== 32'h1000 + 32'(i) * 32'h0111) begin
                n_err++; $display("FAIL stream%0d_data got %h want %h", i, out_data, 32'h1000 + 32'(i) * 32'h0111); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream%0d_ready got %b want 1", i, in_ready); end
            if (i < 7) in_imm = 16'h1000 + 16'(i + 1) * 16'h0111;
            else in_valid = 1'b0;
        end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_end_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h8001;           // A -> FFFF8001
        tick();
        n_vec++; if (out_data !== 32'hFFFF8001 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_a_or got %b/%h want 1/ffff8001", out_valid, out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_a_ready got %b want 1", in_ready); end
        in_mode = 2'b00; in_imm = 16'h00AB;                              // B -> 000000AB
        tick();
        n_vec++; if (out_data !== 32'hFFFF8001) begin n_err++; $display("FAIL bp_b_hold got %h want ffff8001", out_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_b_ready got %b want 0", in_ready); end
        in_mode = 2'b10; in_imm = 16'h00CD;                              // C -> 00CD0000
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF8001) begin n_err++; $display("FAIL bp_stall%0d got %b/%h want 1/ffff8001", i, out_valid, out_data); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d_ready got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 32'h000000AB) begin n_err++; $display("FAIL bp_out_b got %b/%h want 1/000000ab", out_valid, out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_out_b_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_data !== 32'h00CD0000) begin n_err++; $display("FAIL bp_out_c got %b/%h want 1/00cd0000", out_valid, out_data); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'hF00D;
        tick();
        in_imm = 16'h0BAD;
        tick();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL mr_full got rdy %b vld %b want 0/1", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_flush got %b want 0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL mr_edge got %b/%h want 0/00000000", out_valid, out_data); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_stale%0d got %b want 0", i, out_valid); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready%0d got %b want 1", i, in_ready); end
        end
    endtask

`ifdef IMMEXT_STATS_EN
    task automatic test_stats();
        logic [15:0] im [5] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0002, 16'h9000};
        out_ready = 1'b1; stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        in_mode = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_imm = im[i];
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        n_vec++; if (stat_neg_cnt !== 16'd3) begin n_err++; $display("FAIL stat_count got %0d want 3", stat_neg_cnt); end
        in_valid = 1'b1; in_imm = 16'h8123;
        tick();
        in_valid = 1'b0; stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_vec++; if (stat_neg_cnt !== 16'd0) begin n_err++; $display("FAIL stat_clr got %0d want 0", stat_neg_cnt); end
        force dut.stat_cnt_q = 16'hFFFF;
        tick();
        release dut.stat_cnt_q;
        in_valid = 1'b1; in_imm = 16'h8456;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        n_vec++; if (stat_neg_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stat_sat got %h want ffff", stat_neg_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_modes();
        test_streaming();
        test_back_to_back();
        test_mid_reset();
`ifdef IMMEXT_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
